apb_cfg_slave: RTL and testbench
================================

APB_CFG_SLAVE -- requirements
Module: apb_cfg_slave

Interface
REQ-001 Parameter NUM_REGS, default 8: number of config registers served; legal range 1..64.
REQ-002 Parameter REG_ADDR_WIDTH, default 32: APB address width.
REQ-003 Parameter REG_DATA_WIDTH, default 32: register/APB data width.
REQ-004 Parameter BASE_ADDR, default 32'h0: byte address of register 0; register i is at BASE_ADDR + 4*i.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 psel  input  1  APB select.
REQ-008 penable  input  1  APB enable (ACCESS phase).
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  REG_ADDR_WIDTH  APB byte address.
REQ-011 pwdata  input  REG_DATA_WIDTH  APB write data.
REQ-012 prdata  output  REG_DATA_WIDTH  read data, valid when pready=1 and pwrite=0.
REQ-013 pready  output  1  transfer completion.
REQ-014 pslverr  output  1  error response, valid only when pready=1.
REQ-015 cfg_vld  output  NUM_REGS  one-hot write strobe per register, to downstream config registers.
REQ-016 cfg_data  output  REG_DATA_WIDTH  shared write data to all config registers.
REQ-017 reg_data_bus  input  NUM_REGS*REG_DATA_WIDTH  readback; register i occupies bits [i*W +: W].

Function
REQ-018 FSM SHALL have two states: IDLE, RESP.
REQ-019 IDLE -> RESP when psel=1 and penable=1; otherwise stay in IDLE.
REQ-020 RESP -> IDLE unconditionally after one cycle, regardless of psel/penable.
REQ-021 pready SHALL be registered: 1 only in RESP, so every transfer has exactly one wait state (first ACCESS cycle pready=0, second pready=1).
REQ-022 Address hit: paddr[1:0]==0 and BASE_ADDR <= paddr < BASE_ADDR+4*NUM_REGS; index = (paddr-BASE_ADDR)>>2.
REQ-023 Decode, pwrite and pwdata SHALL be sampled on the IDLE->RESP edge only.
REQ-024 Write hit: cfg_vld[index]=1 for exactly the RESP cycle, all other bits 0; cfg_data=sampled pwdata in the same cycle.
REQ-025 cfg_data SHALL hold its last value outside write strobes; cfg_vld SHALL be all-zero outside RESP.
REQ-026 Read hit: prdata = reg_data_bus slice[index] sampled on the IDLE->RESP edge, held through RESP.
REQ-027 Miss (unaligned or out of range): pslverr=1 in RESP, cfg_vld all-zero, prdata=0.
REQ-028 pslverr SHALL be 0 whenever pready=0; prdata SHALL be 0 in IDLE and for writes.
REQ-029 A write completing in cycle T is visible downstream at T+1; a read whose ACCESS starts at T+2 or later SHALL return the new value.
REQ-030 Back-to-back transfers (SETUP immediately after RESP) SHALL each complete with one wait state and no lost strobe.
REQ-031 psel deasserted while in RESP (protocol violation): transfer SHALL still complete normally, then IDLE.

Reset
REQ-032 rstn=0 SHALL force immediately: state IDLE, pready=0, pslverr=0, prdata=0, cfg_vld=0, cfg_data=0.
REQ-033 Reset asserted during RESP SHALL abort the transfer; no cfg_vld pulse after rstn deasserts; first post-reset ACCESS treated as new transfer.

Verification
REQ-034 Write 32'hDEADBEEF to BASE+0x8 -> pready low 1 cycle then high; cfg_vld=8'b0000_0100 for one cycle; cfg_data=32'hDEADBEEF; pslverr=0.
REQ-035 reg_data_bus slice 5 = 32'h1234_5678, read BASE+0x14 -> prdata=32'h1234_5678 with pready=1, pslverr=0, cfg_vld=0.
REQ-036 Write BASE+0x20 (NUM_REGS=8) and read BASE+0x6 -> pslverr=1 with pready=1, cfg_vld=0, prdata=0.
REQ-037 Write 32'hA5 to BASE+0x0, then back-to-back read BASE+0x0 through a downstream config register model -> read returns 32'hA5.
REQ-038 Assert rstn=0 during RESP of a write -> all outputs 0 immediately, no strobe after release; subsequent write to BASE+0x4 strobes cfg_vld[1] normally.

Source files
------------

// File: rtl/apb_cfg_slave.sv
// rtl/apb_cfg_slave.sv - APB slave bridging to a bank of downstream config registers
module apb_cfg_slave #(
  parameter int                        NUM_REGS       = 8,
  parameter int                        REG_ADDR_WIDTH = 32,
  parameter int                        REG_DATA_WIDTH = 32,
  parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               psel,
  input  logic                               penable,
  input  logic                               pwrite,
  input  logic [REG_ADDR_WIDTH-1:0]          paddr,
  input  logic [REG_DATA_WIDTH-1:0]          pwdata,
  output logic [REG_DATA_WIDTH-1:0]          prdata,
  output logic                               pready,
  output logic                               pslverr,
  output logic [NUM_REGS-1:0]                cfg_vld,
  output logic [REG_DATA_WIDTH-1:0]          cfg_data,
  input  logic [NUM_REGS*REG_DATA_WIDTH-1:0] reg_data_bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Byte span of the register window, one bit wider than the address so it never wraps.
  localparam logic [REG_ADDR_WIDTH:0] SPAN = (REG_ADDR_WIDTH+1)'(4 * NUM_REGS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic                        start;
  logic [REG_ADDR_WIDTH-1:0]   addr_off;
  logic                        hit;
  logic [IDX_W-1:0]            reg_idx;
  logic [REG_DATA_WIDTH-1:0]   rd_slice;
  logic [NUM_REGS-1:0]         wr_onehot;
  logic                        pready_d;
  logic                        pslverr_d;
  logic [REG_DATA_WIDTH-1:0]   prdata_d;
  logic [NUM_REGS-1:0]         cfg_vld_d;
  logic [REG_DATA_WIDTH-1:0]   cfg_data_d;

  // A transfer is accepted only on the first ACCESS cycle seen in IDLE.
  assign start = (state == IDLE) && psel && penable;

  // Address decode: aligned and inside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS).
  always_comb begin
    addr_off = paddr - BASE_ADDR;
    hit      = (paddr[1:0] == 2'b00) && (paddr >= BASE_ADDR) && ({1'b0, addr_off} < SPAN);
    reg_idx  = addr_off[IDX_W+1:2];
  end

  // Readback mux and write strobe decode from the register index.
  always_comb begin
    rd_slice  = '0;
    wr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_idx == IDX_W'(i)) begin
        rd_slice     = reg_data_bus[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        wr_onehot[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: accept on ACCESS, RESP always lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (psel && penable) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output next values: everything is captured on the IDLE->RESP edge and cleared leaving RESP.
  always_comb begin
    pready_d   = start;
    pslverr_d  = start && !hit;
    prdata_d   = (start && !pwrite && hit) ? rd_slice : '0;
    cfg_vld_d  = (start && pwrite && hit) ? wr_onehot : '0;
    cfg_data_d = (start && pwrite && hit) ? pwdata : cfg_data;
  end

  // Output registers; asynchronous reset clears them immediately, aborting any RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      cfg_vld  <= '0;
      cfg_data <= '0;
    end else begin
      pready   <= pready_d;
      pslverr  <= pslverr_d;
      prdata   <= prdata_d;
      cfg_vld  <= cfg_vld_d;
      cfg_data <= cfg_data_d;
    end
  end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// tb/tb_apb_cfg_slave.sv - scoreboard bench for apb_cfg_slave
module tb_apb_cfg_slave;

  logic         clk;
  logic         rstn;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic [7:0]   cfg_vld;
  logic [31:0]  cfg_data;
  logic [255:0] reg_data_bus;

  int total = 0;
  int bad   = 0;
  int wait_cnt = 0;
  int resp_id  = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  vld;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] model [8];

  apb_cfg_slave #(
    .NUM_REGS(8), .REG_ADDR_WIDTH(32), .REG_DATA_WIDTH(32), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cfg_vld(cfg_vld), .cfg_data(cfg_data),
    .reg_data_bus(reg_data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream config register model
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) model[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 8; i++) if (cfg_vld[i]) model[i] <= cfg_data;
    end
  end

  always_comb begin
    reg_data_bus = '0;
    for (int i = 0; i < 8; i++) reg_data_bus[i*32 +: 32] = model[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: idle-state checks every cycle, scoreboard pop on every completion
  always @(negedge clk) begin
    if (!rstn) begin
      wait_cnt = 0;
    end else if (!pready) begin
      if (psel && penable) wait_cnt++;
      chk("idle_slverr", {31'b0, pslverr}, 32'h0);
      chk("idle_vld", {24'b0, cfg_vld}, 32'h0);
      chk("idle_prdata", prdata, 32'h0);
    end else begin
      exp_t e;
      resp_id++;
      chk($sformatf("wait_states[%0d]", resp_id), wait_cnt, 32'd1);
      wait_cnt = 0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp[%0d] act=pready exp=none", resp_id);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("prdata[%0d]", resp_id), prdata, e.rd);
        chk($sformatf("pslverr[%0d]", resp_id), {31'b0, pslverr}, {31'b0, e.err});
        chk($sformatf("cfg_vld[%0d]", resp_id), {24'b0, cfg_vld}, {24'b0, e.vld});
        if (e.chk_data) chk($sformatf("cfg_data[%0d]", resp_id), cfg_data, e.data);
      end
    end
  end

  // One APB transfer starting just after a rising edge; ends just after the RESP cycle.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] e_rd, input logic e_err, input logic [7:0] e_vld,
                     input logic chk_d, input logic [31:0] e_data, input logic drop_psel);
    exp_t e;
    e.rd = e_rd; e.err = e_err; e.vld = e_vld; e.chk_data = chk_d; e.data = e_data;
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    if (drop_psel) begin psel = 1'b0; penable = 1'b0; end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    #1;
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_slverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_vld", {24'b0, cfg_vld}, 32'h0);
    chk("rst_cfg_data", cfg_data, 32'h0);
    idle(3);
    rstn = 1'b1;
    idle(2);

    // wr, addr, wdata, exp_rd, exp_err, exp_vld, chk_data, exp_data, drop_psel
    apb(1, 32'h08, 32'hDEADBEEF, 32'h0,        0, 8'b0000_0100, 1, 32'hDEADBEEF, 0);
    idle(1);
    apb(1, 32'h14, 32'h12345678, 32'h0,        0, 8'b0010_0000, 1, 32'h12345678, 0);
    idle(1);
    apb(0, 32'h14, 32'h0,        32'h12345678, 0, 8'h00,        0, 32'h0,        0);
    apb(0, 32'h08, 32'h0,        32'hDEADBEEF, 0, 8'h00,        0, 32'h0,        0);
    idle(1);
    // Misses: just past the window, unaligned, and cfg_data must hold
    apb(1, 32'h20, 32'hFFFF0000, 32'h0,        1, 8'h00,        1, 32'h12345678, 0);
    apb(0, 32'h06, 32'h0,        32'h0,        1, 8'h00,        1, 32'h12345678, 0);
    apb(0, 32'h03, 32'h0,        32'h0,        1, 8'h00,        0, 32'h0,        0);
    idle(1);
    // Last register boundary, back-to-back write then read
    apb(1, 32'h1C, 32'h00000077, 32'h0,        0, 8'b1000_0000, 1, 32'h00000077, 0);
    apb(0, 32'h1C, 32'h0,        32'h00000077, 0, 8'h00,        0, 32'h0,        0);
    // Write then back-to-back readback through the downstream model
    apb(1, 32'h00, 32'h000000A5, 32'h0,        0, 8'b0000_0001, 1, 32'h000000A5, 0);
    apb(0, 32'h00, 32'h0,        32'h000000A5, 0, 8'h00,        0, 32'h0,        0);
    idle(1);
    // psel dropped during RESP still completes normally
    apb(1, 32'h10, 32'h00000055, 32'h0,        0, 8'b0001_0000, 1, 32'h00000055, 1);
    apb(0, 32'h10, 32'h0,        32'h00000055, 0, 8'h00,        0, 32'h0,        0);
    idle(2);

    // Reset asserted in RESP of a write aborts it
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h00000BAD;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    chk("abort_pready", {31'b0, pready}, 32'h0);
    chk("abort_slverr", {31'b0, pslverr}, 32'h0);
    chk("abort_prdata", prdata, 32'h0);
    chk("abort_vld", {24'b0, cfg_vld}, 32'h0);
    chk("abort_cfg_data", cfg_data, 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(3);
    apb(1, 32'h04, 32'h0000CAFE, 32'h0,        0, 8'b0000_0010, 1, 32'h0000CAFE, 0);
    apb(0, 32'h04, 32'h0,        32'h0000CAFE, 0, 8'h00,        0, 32'h0,        0);
    apb(0, 32'h0C, 32'h0,        32'h0,        0, 8'h00,        0, 32'h0,        0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
